// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - host request/response and bus control signals for bus_master
interface bus_master_if #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_rw;
  logic [DATA_W-1:0]             req_addr;
  logic [BURST_LEN*DATA_W-1:0]   req_wdata;
  logic                          rsp_valid;
  logic [BURST_LEN*DATA_W-1:0]   rsp_rdata;
  logic                          AddrValid;
  logic                          rw;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, AddrValid, rw
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, AddrValid, rw
  );
endinterface

// File: rtl/bus_master.sv
// rtl/bus_master.sv - turns one host request into an address cycle plus a data burst on AddrData
module bus_master #(
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              resetH,
  bus_master_if.master      bus,
  inout  wire [DATA_W-1:0]  AddrData
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                      state;
  logic [BW-1:0]               beat;
  logic [BURST_LEN*DATA_W-1:0] wdata_q;
  logic                        bus_oe;
  logic [DATA_W-1:0]           bus_dout;

  assign AddrData = bus_oe ? bus_dout : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (resetH) begin
      state         <= IDLE;
      beat          <= '0;
      wdata_q       <= '0;
      bus_oe        <= 1'b0;
      bus_dout      <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.AddrValid <= 1'b0;
      bus.rw        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.rsp_valid <= 1'b0;
          if (bus.req_valid && bus.req_ready) begin
            state         <= ADDR;
            bus.req_ready <= 1'b0;
            bus.AddrValid <= 1'b1;
            bus.rw        <= bus.req_rw;
            bus_oe        <= 1'b1;
            bus_dout      <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
          end
        end
        ADDR: begin
          state         <= DATA;
          beat          <= '0;
          bus.AddrValid <= 1'b0;
          bus_oe        <= ~bus.rw;
          bus_dout      <= wdata_q[DATA_W-1:0];
          wdata_q       <= wdata_q >> DATA_W;
        end
        DATA: begin
          // Read words shift in from the top so word 0 lands in the low slot after the last beat.
          if (bus.rw)
            bus.rsp_rdata <= {AddrData, bus.rsp_rdata[BURST_LEN*DATA_W-1:DATA_W]};
          bus_dout <= wdata_q[DATA_W-1:0];
          wdata_q  <= wdata_q >> DATA_W;
          if (beat == BW'(BURST_LEN - 1)) begin
            state         <= DONE;
            bus.rsp_valid <= 1'b1;
            bus.rw        <= 1'b0;
            bus_oe        <= 1'b0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
